l1_dcache: RTL and testbench
============================

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache for the LC-3b pipeline.
- Responder end of the CPU MEM-stage memory interface: address, read, write, byte enable, wdata, rdata, resp.
- Initiator toward physical memory over a 128-bit line interface.
- Hits complete in the request cycle. Misses stall the requester, via its read/write-and-not-resp stall rule, until a writeback and/or fill finishes.

Parameters:
NUM_SETS, 8, number of cache lines; power of two, 2 to 64
LINE_BYTES, 16, bytes per line; fixed, 128-bit line, offset = address[3:0]

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
mem_address  in  16  CPU byte address; bit 0 ignored for word select
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  2  [1] = upper byte, [0] = lower byte of mem_wdata
mem_wdata  in  16  CPU write data
mem_rdata  out  16  selected word of the addressed line
mem_resp  out  1  request complete this cycle
pmem_address  out  16  line-aligned physical address, [3:0] = 0
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_wdata  out  128  victim line data
pmem_rdata  in  128  fill data
pmem_resp  in  1  physical memory completion

Behaviour:
- Address split: offset [3:0]; word = [3:1]; index = [3+log2(NUM_SETS):4]; tag = remaining upper bits.
- Per-line state: valid bit, dirty bit, tag, 128-bit data.
  - reset clears all valid and dirty bits.
  - Tag and data arrays are not reset.
- States: IDLE, WRITEBACK, FILL. Reset forces IDLE in the cycle after the reset edge.
- Reset values: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, mem_rdata=0 when no request; in-flight request is abandoned.
- IDLE, hit:
  - Hit = request active, line valid, tags equal.
  - mem_resp=1 combinationally in the same cycle.
  - Read: mem_rdata = line word[word].
  - Write: enabled bytes are merged into line word[word] at the clock edge and dirty is set.
- IDLE, miss:
  - Valid and dirty line: go to WRITEBACK.
  - Otherwise: go to FILL.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address = {stored tag, index, 4'b0}, pmem_wdata = line data, all held stable.
  - On pmem_resp go to FILL.
- FILL:
  - pmem_read=1, pmem_address = {request tag, index, 4'b0}.
  - On pmem_resp, load pmem_rdata into the line, write the tag, set valid, clear dirty, go to IDLE.
  - The next cycle is a hit, so miss latency = memory latency + 1 cycle.
- mem_read and mem_write both high: treated as a write; read is ignored.
- mem_byte_enable=00 on a write: hit completes with resp, line contents unchanged, dirty still set.
- pmem_resp in IDLE is ignored.
- Requester changing its address mid-miss is unsupported. The fill completes into the original index, then the new address is evaluated.
- No request active: mem_resp=0, no state change.

Optional Feature:
DCACHE_PERF_EN:
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments once per mem_resp cycle that did not follow a fill.
  - miss_count increments once per IDLE-to-WRITEBACK or IDLE-to-FILL transition.
  - Both are cleared by reset and wrap 0xFFFF to 0x0000.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold read miss:
  - Stimulus: read 0x1236 after reset, memory returns line 0x...AAAA_BBBB_CCCC_DDDD after 3 cycles.
  - Response: pmem_read with pmem_address=0x1230; then mem_resp with mem_rdata = word 3 of the line; miss_count=1.
- Write hit byte masking:
  - Stimulus: hit on 0x1234 holding 0x1111, write 0xABCD with byte_enable=10.
  - Response: subsequent read returns 0xAB11; no pmem activity.
- Dirty eviction:
  - Stimulus: write 0x1230 := 0x5555, then read 0x5230 (same index, different tag).
  - Response: pmem_write at 0x1230 with word 0 = 0x5555 first, then pmem_read at 0x5230.
- Clean eviction:
  - Stimulus: read 0x0040, then read 0x8040.
  - Response: no pmem_write; one pmem_read at 0x8040.
- Reset mid-fill:
  - Stimulus: assert reset while pmem_read=1.
  - Response: next cycle pmem_read=0, mem_resp=0; re-read of the same address misses again.
- Write-allocate:
  - Stimulus: write to an uncached address 0x2002 := 0x00FF, byte_enable=11.
  - Response: fill from 0x2000, then resp; line dirty; later eviction writes back 0x00FF in word 1.

Source files
------------

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache, 128-bit lines.
// Define DCACHE_PERF_EN to add hit_count/miss_count outputs.
module l1_dcache #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
`ifdef DCACHE_PERF_EN
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count,
`endif
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;
  localparam int LW = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  state_t state, state_n;

  logic [NUM_SETS-1:0] valid, dirty;
  logic [TW-1:0] tags [NUM_SETS];
  logic [LW-1:0] lines [NUM_SETS];

  logic [IW-1:0] idx, miss_idx;
  logic [TW-1:0] tag, miss_tag;
  logic [2:0]    word;
  logic [LW-1:0] cur_line;
  logic          req, hit, miss, fill_done;
  logic          unused_bit;

  assign idx        = mem_address[4 +: IW];
  assign tag        = mem_address[15 -: TW];
  assign word       = mem_address[3:1];
  assign unused_bit = mem_address[0];
  assign req        = mem_read | mem_write;
  assign cur_line   = lines[idx];

  assign hit = !reset && state == IDLE && req
             && valid[idx] && tags[idx] == tag;
  assign miss = !reset && state == IDLE && req && !hit;
  assign fill_done = state == FILL && pmem_resp;

  always_comb begin
    state_n      = state;
    mem_resp     = hit;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (hit && !mem_write)
      mem_rdata = cur_line[{word, 4'b0000} +: 16];
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (miss)
            state_n = (valid[idx] && dirty[idx])
                    ? WRITEBACK : FILL;
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          pmem_address = {tags[miss_idx], miss_idx, 4'b0000};
          pmem_wdata   = lines[miss_idx];
          if (pmem_resp)
            state_n = FILL;
        end
        FILL: begin
          pmem_read    = 1'b1;
          pmem_address = {miss_tag, miss_idx, 4'b0000};
          if (pmem_resp)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Miss index/tag are latched so the fill lands in the original line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      state <= state_n;
      if (miss) begin
        miss_idx <= idx;
        miss_tag <= tag;
      end
      if (hit && mem_write)
        dirty[idx] <= 1'b1;
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit && mem_write) begin
      if (mem_byte_enable[0])
        lines[idx][{word, 4'b0000} +: 8] <= mem_wdata[7:0];
      if (mem_byte_enable[1])
        lines[idx][{word, 4'b1000} +: 8] <= mem_wdata[15:8];
    end
    if (!reset && fill_done) begin
      lines[miss_idx] <= pmem_rdata;
      tags[miss_idx]  <= miss_tag;
    end
  end

`ifdef DCACHE_PERF_EN
  logic after_fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      after_fill <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      after_fill <= fill_done;
      if (mem_resp && !after_fill)
        hit_count <= hit_count + 16'd1;
      if (miss)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Testbench for l1_dcache: vector table, pmem model, scoreboards.
// Counter checks are compiled in when DCACHE_PERF_EN is defined.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef DCACHE_PERF_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk(clk),
    .reset(reset),
`ifdef DCACHE_PERF_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_address(pmem_address),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [15:0] rdata;
  } rexp_t;

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } pexp_t;

  typedef struct {
    logic         rd, wr;
    logic [15:0]  addr;
    logic [1:0]   be;
    logic [15:0]  wdata;
    logic         chk;
    logic [15:0]  rdata;
    logic         hit;
    logic         wb;
    logic [15:0]  wb_addr;
    logic [127:0] wb_data;
    logic         fill;
    logic [15:0]  fill_addr;
  } vec_t;

  rexp_t rq[$];
  pexp_t pq[$];
  vec_t  v[$];
  logic [127:0] mem [logic [11:0]];
  int cnt = 0;

  function automatic logic [127:0] init_line(logic [11:0] la);
    logic [127:0] l;
    for (int i = 0; i < 8; i++)
      l[i*16 +: 16] = {la, 4'(i)} ^ 16'h5A00;
    return l;
  endfunction

  function automatic logic [127:0] get_line(logic [11:0] la);
    if (mem.exists(la))
      return mem[la];
    return init_line(la);
  endfunction

  function automatic vec_t mk(
    logic rd, logic wr, logic [15:0] a, logic [1:0] be,
    logic [15:0] wd, logic chk, logic [15:0] rdat, logic hit,
    logic wb, logic [15:0] wba, logic [127:0] wbd,
    logic fill, logic [15:0] fa);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.be = be;
    t.wdata = wd; t.chk = chk; t.rdata = rdat; t.hit = hit;
    t.wb = wb; t.wb_addr = wba; t.wb_data = wbd;
    t.fill = fill; t.fill_addr = fa;
    return t;
  endfunction

  task automatic pm_check(logic wr, logic [15:0] a,
                          logic [127:0] d);
    pexp_t e;
    checks++;
    if (pq.size() == 0) begin
      errors++;
      $display("FAIL pmem_unexpected got wr=%0b addr=%h want none",
               wr, a);
      return;
    end
    e = pq.pop_front();
    if (wr !== e.wr || a !== e.addr || (wr && d !== e.data)) begin
      errors++;
      $display("FAIL pmem_op got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
               wr, a, d, e.wr, e.addr, e.data);
    end
  endtask

  // Physical memory: responds 3 cycles after a request appears.
  always @(negedge clk) begin
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pmem_read || pmem_write) begin
      cnt++;
      if (cnt == 3) begin
        pm_check(pmem_write, pmem_address, pmem_wdata);
        if (pmem_write)
          mem[pmem_address[15:4]] = pmem_wdata;
        else
          pmem_rdata = get_line(pmem_address[15:4]);
        pmem_resp = 1'b1;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic cpu_op(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic chk,
                        input logic [15:0] exp_rd,
                        output int lat);
    rexp_t r;
    @(posedge clk); #1;
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    r.chk = chk;
    r.rdata = exp_rd;
    rq.push_back(r);
    lat = 0;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        r = rq.pop_front();
        if (r.chk) begin
          checks++;
          if (mem_rdata !== r.rdata) begin
            errors++;
            $display("FAIL rdata addr=%h got %h want %h",
                     a, mem_rdata, r.rdata);
          end
        end
        break;
      end
      lat++;
      if (lat > 60) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout addr=%h got no resp want resp", a);
        void'(rq.pop_front());
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic chk(string name, logic [127:0] got,
                     logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [127:0] l123, wb123, wb200;
    int lat, n, exp_hits, exp_miss;
    pexp_t p;

    reset = 1'b1;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = '0;
    mem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;

    l123 = 128'h1111_2222_3333_4444_AAAA_BBBB_CCCC_DDDD;
    wb123 = 128'h1111_2222_3333_4444_AAAA_AB11_CCCC_5555;
    wb200 = init_line(12'h200);
    wb200[31:16] = 16'h00FF;
    mem[12'h123] = l123;

    v.push_back(mk(1,0,16'h1236,2'b00,16'h0,1,16'hAAAA,0,
                   0,16'h0,'0,1,16'h1230));
    v.push_back(mk(1,0,16'h1230,2'b00,16'h0,1,16'hDDDD,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(0,1,16'h1234,2'b11,16'h1111,0,16'h0,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(0,1,16'h1234,2'b10,16'hABCD,0,16'h0,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'h1234,2'b00,16'h0,1,16'hAB11,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(0,1,16'h1230,2'b11,16'h5555,0,16'h0,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(0,1,16'h1232,2'b00,16'hFFFF,0,16'h0,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'h1232,2'b00,16'h0,1,16'hCCCC,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'h5230,2'b00,16'h0,1,
                   16'h5230 ^ 16'h5A00,0,
                   1,16'h1230,wb123,1,16'h5230));
    v.push_back(mk(1,0,16'h0040,2'b00,16'h0,1,
                   16'h0040 ^ 16'h5A00,0,
                   0,16'h0,'0,1,16'h0040));
    v.push_back(mk(1,0,16'h8046,2'b00,16'h0,1,
                   16'h8043 ^ 16'h5A00,0,
                   0,16'h0,'0,1,16'h8040));
    v.push_back(mk(1,1,16'h8042,2'b11,16'h7777,0,16'h0,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'h8042,2'b00,16'h0,1,16'h7777,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(0,1,16'h2002,2'b11,16'h00FF,0,16'h0,0,
                   0,16'h0,'0,1,16'h2000));
    v.push_back(mk(1,0,16'h2002,2'b00,16'h0,1,16'h00FF,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'hA000,2'b00,16'h0,1,
                   16'hA000 ^ 16'h5A00,0,
                   1,16'h2000,wb200,1,16'hA000));
    v.push_back(mk(1,0,16'h5230,2'b00,16'h0,1,
                   16'h5230 ^ 16'h5A00,1,
                   0,16'h0,'0,0,16'h0));
    v.push_back(mk(1,0,16'h1230,2'b00,16'h0,1,16'h5555,0,
                   0,16'h0,'0,1,16'h1230));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_mem_rdata", 128'(mem_rdata), 128'(0));

    exp_hits = 0;
    exp_miss = 0;
    for (int i = 0; i < v.size(); i++) begin
      if (v[i].wb) begin
        p.wr = 1'b1;
        p.addr = v[i].wb_addr;
        p.data = v[i].wb_data;
        pq.push_back(p);
      end
      if (v[i].fill) begin
        p.wr = 1'b0;
        p.addr = v[i].fill_addr;
        p.data = '0;
        pq.push_back(p);
      end
      if (v[i].hit) exp_hits++;
      else exp_miss++;
      cpu_op(v[i].rd, v[i].wr, v[i].addr, v[i].be, v[i].wdata,
             v[i].chk, v[i].rdata, lat);
      checks++;
      if ((lat == 0) !== v[i].hit) begin
        errors++;
        $display("FAIL hit_%0d got hit=%0b want %0b",
                 i, lat == 0, v[i].hit);
      end
    end
    chk("pmem_pending", 128'(pq.size()), 128'(0));
`ifdef DCACHE_PERF_EN
    chk("hit_count", 128'(hit_count), 128'(exp_hits));
    chk("miss_count", 128'(miss_count), 128'(exp_miss));
`endif

    // Reset while a fill is outstanding.
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = 16'h3000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read && n < 10);
    checks++;
    if (!pmem_read) begin
      errors++;
      $display("FAIL fill_start got pmem_read=0 want 1");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmf_pmem_read", 128'(pmem_read), 128'(0));
    chk("rmf_mem_resp", 128'(mem_resp), 128'(0));
`ifdef DCACHE_PERF_EN
    chk("rmf_hit_count", 128'(hit_count), 128'(0));
    chk("rmf_miss_count", 128'(miss_count), 128'(0));
`endif
    p.wr = 1'b0;
    p.addr = 16'h3000;
    p.data = '0;
    pq.push_back(p);
    cpu_op(1'b1, 1'b0, 16'h3000, 2'b00, 16'h0, 1'b1,
           16'h3000 ^ 16'h5A00, lat);
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL rmf_reread got hit want miss");
    end
    chk("pmem_pending_end", 128'(pq.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
